uart_cmd_parser: RTL and testbench

ASCII register-access command parser directly downstream of the `uart` block's receive FIFO and upstream of its transmit FIFO. It pops bytes from the RX FIFO and decodes hex read/write commands. It drives a simple 8-bit register bus and writes the ASCII response into the TX FIFO. It gives the host PC access to the accelerometer SoC control and status registers over the serial link.

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/uart_cmd_hex.sv | 25 ++
 rtl/uart_cmd_parser.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART register-access command parser.
package uart_cmd_pkg;

    localparam logic [7:0] AsciiR     = 8'h52;
    localparam logic [7:0] AsciiW     = 8'h57;
    localparam logic [7:0] AsciiK     = 8'h4B;
    localparam logic [7:0] AsciiQmark = 8'h3F;
    localparam logic [7:0] AsciiCr    = 8'h0D;
    localparam logic [7:0] AsciiLf    = 8'h0A;

    localparam logic [2:0] RespLenRead  = 3'd4;
    localparam logic [2:0] RespLenShort = 3'd3;

    typedef enum logic [3:0] {
        StIdle, StAddrHi, StAddrLo, StDataHi, StDataLo,
        StWaitCr, StDrain, StExec, StRdWait, StResp
    } state_e;

    typedef enum logic [1:0] {RespRead, RespAck, RespErr} resp_e;

    // Only 'R'/'r' and 'W'/'w' map onto the lower-case letters compared against.
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        return c | 8'h20;
    endfunction

endpackage

// File: rtl/uart_cmd_hex.sv
// ASCII hex digit to nibble (with valid flag) and nibble to upper-case ASCII.
module uart_cmd_hex (
    input  logic [7:0] ascii_i,
    output logic [3:0] nibble_o,
    output logic       valid_o,
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        nibble_o = 4'h0;
        valid_o  = 1'b0;
        if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
            nibble_o = ascii_i[3:0];
            valid_o  = 1'b1;
        end else if ((ascii_i >= 8'h41 && ascii_i <= 8'h46) ||
                     (ascii_i >= 8'h61 && ascii_i <= 8'h66)) begin
            nibble_o = ascii_i[3:0] + 4'd9;
            valid_o  = 1'b1;
        end
    end

    assign ascii_o = (nibble_i < 4'd10) ? {4'h3, nibble_i} : (8'h37 + {4'h0, nibble_i});

endmodule

// File: rtl/uart_cmd_parser.sv
// Hex register read/write command parser between the UART RX and TX FIFOs.
// Define UART_CMD_ECHO_EN to echo every popped byte back to the TX FIFO.
module uart_cmd_parser #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] receive_data,
    input  logic       receive_data_preset,
    output logic       buffer_read,
    output logic [7:0] transmit_data,
    output logic       buffer_write,
    input  logic       transmit_full,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    import uart_cmd_pkg::*;

    localparam logic [1:0] RdLast = 2'(RD_LATENCY - 1);

    state_e      state_q;
    resp_e       kind_q;
    logic        write_q;
    logic [1:0]  idx_q, cnt_q;
    logic [7:0]  addr_sh_q, data_sh_q, rdata_q;
    logic        buffer_read_q, buffer_write_q, reg_we_q, reg_re_q, busy_q;
    logic [7:0]  transmit_data_q, reg_addr_q, reg_wdata_q;

    logic [3:0]  rx_nib, enc_nib, unused_enc_nib;
    logic        rx_hex, unused_enc_valid;
    logic [7:0]  enc_ascii, unused_dec_ascii, resp_byte;
    logic [1:0]  resp_last;
    logic        is_cr, is_lf, is_cmd, parse_st, tx_free, tx_ok;

    uart_cmd_hex u_dec (
        .ascii_i  (receive_data),
        .nibble_o (rx_nib),
        .valid_o  (rx_hex),
        .nibble_i (4'h0),
        .ascii_o  (unused_dec_ascii)
    );

    // The first read digit is encoded straight from reg_rdata so it can be pushed on capture.
    assign enc_nib = (state_q == StRdWait) ? reg_rdata[7:4] :
                     (idx_q[0] ? rdata_q[3:0] : rdata_q[7:4]);

    uart_cmd_hex u_enc (
        .ascii_i  (8'h00),
        .nibble_o (unused_enc_nib),
        .valid_o  (unused_enc_valid),
        .nibble_i (enc_nib),
        .ascii_o  (enc_ascii)
    );

`ifdef UART_CMD_ECHO_EN
    logic       echo_pend_q;
    logic [7:0] echo_byte_q;
    assign tx_free = ~echo_pend_q;
`else
    assign tx_free = 1'b1;
`endif

    assign is_cr    = (receive_data == AsciiCr);
    assign is_lf    = (receive_data == AsciiLf);
    assign is_cmd   = (to_lower(receive_data) == to_lower(AsciiR)) ||
                      (to_lower(receive_data) == to_lower(AsciiW));
    assign parse_st = state_q inside {StIdle, StAddrHi, StAddrLo, StDataHi, StDataLo,
                                      StWaitCr, StDrain};
    assign tx_ok    = tx_free & ~transmit_full;
    assign resp_last = (kind_q == RespRead) ? 2'(RespLenRead - 3'd1) : 2'(RespLenShort - 3'd1);

    always_comb begin
        resp_byte = AsciiLf;
        if (idx_q == resp_last)              resp_byte = AsciiLf;
        else if (idx_q == resp_last - 2'd1)  resp_byte = AsciiCr;
        else if (kind_q == RespRead)         resp_byte = enc_ascii;
        else if (kind_q == RespAck)          resp_byte = AsciiK;
        else                                 resp_byte = AsciiQmark;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            kind_q          <= RespErr;
            write_q         <= 1'b0;
            idx_q           <= 2'd0;
            cnt_q           <= 2'd0;
            addr_sh_q       <= 8'h00;
            data_sh_q       <= 8'h00;
            rdata_q         <= 8'h00;
            buffer_read_q   <= 1'b0;
            buffer_write_q  <= 1'b0;
            transmit_data_q <= 8'h00;
            reg_addr_q      <= 8'h00;
            reg_wdata_q     <= 8'h00;
            reg_we_q        <= 1'b0;
            reg_re_q        <= 1'b0;
            busy_q          <= 1'b0;
`ifdef UART_CMD_ECHO_EN
            echo_pend_q     <= 1'b0;
            echo_byte_q     <= 8'h00;
`endif
        end else begin
            buffer_write_q <= 1'b0;
`ifdef UART_CMD_ECHO_EN
            if (echo_pend_q && !transmit_full) begin
                buffer_write_q  <= 1'b1;
                transmit_data_q <= echo_byte_q;
                echo_pend_q     <= 1'b0;
            end
`endif
            if (buffer_read_q) begin
                buffer_read_q <= 1'b0;
`ifdef UART_CMD_ECHO_EN
                if (transmit_full) begin
                    echo_pend_q <= 1'b1;
                    echo_byte_q <= receive_data;
                end else begin
                    buffer_write_q  <= 1'b1;
                    transmit_data_q <= receive_data;
                end
`endif
                if (!is_lf) begin
                    unique case (state_q)
                        StIdle: begin
                            if (is_cmd) begin
                                write_q <= (to_lower(receive_data) == to_lower(AsciiW));
                                state_q <= StAddrHi;
                                busy_q  <= 1'b1;
                            end else if (!is_cr) begin
                                state_q <= StDrain;
                                busy_q  <= 1'b1;
                            end
                        end
                        StAddrHi, StAddrLo, StDataHi, StDataLo: begin
                            if (!rx_hex) begin
                                // A CR that is itself the offending byte ends the command.
                                state_q <= is_cr ? StResp : StDrain;
                                kind_q  <= RespErr;
                                idx_q   <= 2'd0;
                            end else begin
                                unique case (state_q)
                                    StAddrHi: begin
                                        addr_sh_q[7:4] <= rx_nib;
                                        state_q        <= StAddrLo;
                                    end
                                    StAddrLo: begin
                                        addr_sh_q[3:0] <= rx_nib;
                                        state_q        <= write_q ? StDataHi : StWaitCr;
                                    end
                                    StDataHi: begin
                                        data_sh_q[7:4] <= rx_nib;
                                        state_q        <= StDataLo;
                                    end
                                    default: begin
                                        data_sh_q[3:0] <= rx_nib;
                                        state_q        <= StWaitCr;
                                    end
                                endcase
                            end
                        end
                        StWaitCr: begin
                            if (is_cr) begin
                                state_q    <= StExec;
                                reg_addr_q <= addr_sh_q;
                                if (write_q) begin
                                    reg_wdata_q <= data_sh_q;
                                    reg_we_q    <= 1'b1;
                                end else begin
                                    reg_re_q <= 1'b1;
                                end
                            end else begin
                                state_q <= StDrain;
                            end
                        end
                        StDrain: begin
                            if (is_cr) begin
                                state_q <= StResp;
                                kind_q  <= RespErr;
                                idx_q   <= 2'd0;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (parse_st && receive_data_preset && tx_free) begin
                buffer_read_q <= 1'b1;
            end

            unique case (state_q)
                StExec: begin
                    reg_we_q <= 1'b0;
                    reg_re_q <= 1'b0;
                    if (write_q) begin
                        state_q <= StResp;
                        kind_q  <= RespAck;
                        idx_q   <= 2'd0;
                    end else begin
                        state_q <= StRdWait;
                        cnt_q   <= 2'd0;
                    end
                end
                StRdWait: begin
                    if (cnt_q == RdLast) begin
                        rdata_q <= reg_rdata;
                        kind_q  <= RespRead;
                        state_q <= StResp;
                        if (tx_ok) begin
                            buffer_write_q  <= 1'b1;
                            transmit_data_q <= enc_ascii;
                            idx_q           <= 2'd1;
                        end else begin
                            idx_q <= 2'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                StResp: begin
                    if (tx_ok) begin
                        buffer_write_q  <= 1'b1;
                        transmit_data_q <= resp_byte;
                        if (idx_q == resp_last) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            idx_q   <= 2'd0;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign buffer_read   = buffer_read_q;
    assign buffer_write  = buffer_write_q;
    assign transmit_data = transmit_data_q;
    assign reg_addr      = reg_addr_q;
    assign reg_wdata     = reg_wdata_q;
    assign reg_we        = reg_we_q;
    assign reg_re        = reg_re_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: FIFO and register-bus models, table of commands, corner sequences.
// In command strings '.' stands for CR and '~' for LF.
module tb_uart_cmd_parser;

    localparam int unsigned RdLat = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] receive_data;
    logic       receive_data_preset;
    logic       buffer_read;
    logic [7:0] transmit_data;
    logic       buffer_write;
    logic       transmit_full;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    uart_cmd_parser #(.RD_LATENCY(RdLat)) dut (
        .clk                 (clk),
        .reset               (reset),
        .receive_data        (receive_data),
        .receive_data_preset (receive_data_preset),
        .buffer_read         (buffer_read),
        .transmit_data       (transmit_data),
        .buffer_write        (buffer_write),
        .transmit_full       (transmit_full),
        .reg_addr            (reg_addr),
        .reg_wdata           (reg_wdata),
        .reg_we              (reg_we),
        .reg_re              (reg_re),
        .reg_rdata           (reg_rdata),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] rd_val = 8'h00;
    logic [3:0] re_hist = 4'h0;
    logic       pop_due = 1'b0;
    int cyc = 0, last_pop_cyc = 0, underflow = 0;
    int we_cnt, re_cnt, we_lat, re_lat, re_cyc, tx_re_cyc;
    logic [7:0] we_addr, we_data, re_addr;

    initial begin
        receive_data        = 8'h00;
        receive_data_preset = 1'b0;
        reg_rdata           = 8'h00;
    end

    // FIFO, register-bus and strobe monitors, all sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (buffer_read) begin
            last_pop_cyc = cyc;
            if (rxq.size() == 0) underflow++;
        end
        if (reg_we) begin
            we_cnt++;
            we_addr = reg_addr;
            we_data = reg_wdata;
            we_lat  = cyc - last_pop_cyc;
        end
        if (reg_re) begin
            re_cnt++;
            re_addr = reg_addr;
            re_lat  = cyc - last_pop_cyc;
            re_cyc  = cyc;
        end
        if (buffer_write) begin
            txq.push_back(transmit_data);
            if (re_cnt > 0 && tx_re_cyc < 0 && cyc > re_cyc) tx_re_cyc = cyc;
        end
        re_hist   = {re_hist[2:0], reg_re};
        reg_rdata = re_hist[RdLat] ? rd_val : 8'h00;
        if (pop_due && rxq.size() > 0) void'(rxq.pop_front());
        pop_due = buffer_read;
        receive_data        = (rxq.size() > 0) ? rxq[0] : 8'h00;
        receive_data_preset = (rxq.size() > 0);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon;
        txq.delete();
        we_cnt = 0; re_cnt = 0; we_lat = -1; re_lat = -1;
        re_cyc = -1; tx_re_cyc = -1;
        we_addr = 8'h00; we_data = 8'h00; re_addr = 8'h00;
    endtask

    function automatic logic [7:0] tr(input logic [7:0] c);
        if (c == 8'h2E) return 8'h0D;
        if (c == 8'h7E) return 8'h0A;
        return c;
    endfunction

    function automatic string exp_hex(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02h ", r, tr(s[i]));
        return r;
    endfunction

    function automatic string tx_hex();
        string r = "";
        foreach (txq[i]) r = $sformatf("%s%02h ", r, txq[i]);
        return r;
    endfunction

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) rxq.push_back(tr(s[i]));
    endtask

    task automatic wait_idle(output int ok);
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (rxq.size() == 0 && !busy && !buffer_read && !pop_due) begin
                ok = 1;
                break;
            end
        end
        repeat (8) tick();
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got [%s] expected [%s]", name, got, exp);
    endtask

    task automatic check_reset_vals(input string p);
        check_int({p, "_buffer_read"}, int'(buffer_read), 0);
        check_int({p, "_buffer_write"}, int'(buffer_write), 0);
        check_int({p, "_transmit_data"}, int'(transmit_data), 0);
        check_int({p, "_reg_addr"}, int'(reg_addr), 0);
        check_int({p, "_reg_wdata"}, int'(reg_wdata), 0);
        check_int({p, "_reg_we"}, int'(reg_we), 0);
        check_int({p, "_reg_re"}, int'(reg_re), 0);
        check_int({p, "_busy"}, int'(busy), 0);
    endtask

    typedef struct {
        string      cmd;
        logic [7:0] rdata;
        int         we;
        int         re;
        logic [7:0] addr;   // reg_addr after the command (held on error)
        logic [7:0] wdata;  // reg_wdata after the command
        string      resp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    initial begin
        int    ok;
        int    snap;
        string exp;

        vecs[0]  = '{"W3A5C.",   8'h00, 1, 0, 8'h3A, 8'h5C, "K.~"};
        vecs[1]  = '{"r3a.",     8'hE7, 0, 1, 8'h3A, 8'h5C, "E7.~"};
        vecs[2]  = '{"R3G.",     8'h00, 0, 0, 8'h3A, 8'h5C, "?.~"};
        vecs[3]  = '{"W0101.",   8'h00, 1, 0, 8'h01, 8'h01, "K.~"};
        vecs[4]  = '{"wfFa0.",   8'h00, 1, 0, 8'hFF, 8'hA0, "K.~"};
        vecs[5]  = '{"W~C3~9d.", 8'h00, 1, 0, 8'hC3, 8'h9D, "K.~"};
        vecs[6]  = '{"R.",       8'h00, 0, 0, 8'hC3, 8'h9D, "?.~"};
        vecs[7]  = '{"R12X.",    8'h00, 0, 0, 8'hC3, 8'h9D, "?.~"};
        vecs[8]  = '{"Q12.",     8'h00, 0, 0, 8'hC3, 8'h9D, "?.~"};
        vecs[9]  = '{".",        8'h00, 0, 0, 8'hC3, 8'h9D, ""};
        vecs[10] = '{"Rc5.",     8'h3B, 0, 1, 8'hC5, 8'h9D, "3B.~"};
        vecs[11] = '{"r00.",     8'h0F, 0, 1, 8'h00, 8'h9D, "0F.~"};
        vecs[12] = '{"W12345.",  8'h00, 0, 0, 8'h00, 8'h9D, "?.~"};

        reset = 1'b1;
        transmit_full = 1'b0;
        clear_mon();
        repeat (3) tick();
        check_reset_vals("init");
        reset = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < NV; i++) begin
            clear_mon();
            rd_val = vecs[i].rdata;
            send(vecs[i].cmd);
            wait_idle(ok);
            check_int($sformatf("v%0d_done", i), ok, 1);
            exp = vecs[i].resp;
`ifdef UART_CMD_ECHO_EN
            exp = {vecs[i].cmd, exp};
`endif
            check_str($sformatf("v%0d_tx", i), tx_hex(), exp_hex(exp));
            check_int($sformatf("v%0d_we_count", i), we_cnt, vecs[i].we);
            check_int($sformatf("v%0d_re_count", i), re_cnt, vecs[i].re);
            check_int($sformatf("v%0d_reg_addr", i), int'(reg_addr), int'(vecs[i].addr));
            check_int($sformatf("v%0d_reg_wdata", i), int'(reg_wdata), int'(vecs[i].wdata));
            check_int($sformatf("v%0d_busy", i), int'(busy), 0);
            if (vecs[i].we != 0) begin
                check_int($sformatf("v%0d_we_addr", i), int'(we_addr), int'(vecs[i].addr));
                check_int($sformatf("v%0d_we_data", i), int'(we_data), int'(vecs[i].wdata));
                check_int($sformatf("v%0d_cr_to_we", i), we_lat, 1);
            end
            if (vecs[i].re != 0) begin
                check_int($sformatf("v%0d_re_addr", i), int'(re_addr), int'(vecs[i].addr));
                check_int($sformatf("v%0d_cr_to_re", i), re_lat, 1);
                check_int($sformatf("v%0d_re_to_tx", i), tx_re_cyc - re_cyc, RdLat + 1);
            end
        end

        // TX backpressure across a read response, with a write queued behind it.
        clear_mon();
        rd_val = 8'hA5;
        send("R3A.");
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (re_cnt > 0) begin
                ok = 1;
                break;
            end
        end
        check_int("bp_re_seen", ok, 1);
        transmit_full = 1'b1;
        snap = txq.size();
        send("W0102.");
        repeat (20) tick();
        check_int("bp_no_push", txq.size(), snap);
        check_int("bp_no_pop", rxq.size(), 6);
        check_int("bp_busy", int'(busy), 1);
        transmit_full = 1'b0;
        wait_idle(ok);
        check_int("bp_done", ok, 1);
`ifdef UART_CMD_ECHO_EN
        exp = "R3A.A5.~W0102.K.~";
`else
        exp = "A5.~K.~";
`endif
        check_str("bp_tx", tx_hex(), exp_hex(exp));
        check_int("bp_we_count", we_cnt, 1);
        check_int("bp_re_count", re_cnt, 1);
        check_int("bp_reg_addr", int'(reg_addr), 8'h01);
        check_int("bp_reg_wdata", int'(reg_wdata), 8'h02);

        // Reset in the middle of a command.
        clear_mon();
        send("W12");
        repeat (20) tick();
        check_int("mid_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        tick();
        check_reset_vals("mid_rst");
        reset = 1'b0;
        tick();
        clear_mon();
        rd_val = 8'h4C;
        send("R12.");
        wait_idle(ok);
        check_int("post_rst_done", ok, 1);
        exp = "4C.~";
`ifdef UART_CMD_ECHO_EN
        exp = {"R12.", exp};
`endif
        check_str("post_rst_tx", tx_hex(), exp_hex(exp));
        check_int("post_rst_re_count", re_cnt, 1);
        check_int("post_rst_we_count", we_cnt, 0);
        check_int("post_rst_reg_addr", int'(reg_addr), 8'h12);
        check_int("post_rst_reg_wdata", int'(reg_wdata), 8'h00);

        check_int("rx_underflow", underflow, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
